// File: rtl/lot_ticket_sender.sv
// lot_ticket_sender
//   Transmit side of the lottery digit interface. One 5-digit BCD ticket is
//   accepted per start request. Its digits go to the checker one at a time
//   on num/insere. The sender then pulses fim, captures the checker's premio
//   and pulses fim_jogo to rearm the checker. Saturating tallies count the
//   tickets sent and the prizes won.
//
//   Handshake: start is a level request and is looked at only while idle.
//   Once accepted, the ticket is copied internally, so later changes on the
//   ticket input have no effect. The sender does not wait on the checker.
//   The checker must present premio_in during the cycle after the fim
//   strobe. The sender samples it at the end of that cycle.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   start      in   request to send ticket (sampled only when idle)
//   ticket     in   4*NDIG BCD digits, digit 0 (sent first) in the top nibble
//   busy       out  high whenever not idle
//   num        out  digit presented to the checker
//   insere     out  one-cycle strobe, num valid
//   fim        out  one-cycle end-of-entry strobe
//   fim_jogo   out  one-cycle checker rearm strobe
//   premio_in  in   prize code from checker (01 p1, 10 p2, 00/11 none)
//   result     out  captured prize of the last ticket
//   done       out  one-cycle completion strobe
//   bad_digit  out  one-cycle strobe alongside done for a rejected ticket
//   n_tickets  out  valid tickets completed (saturating)
//   n_p1       out  prize-1 count (saturating)
//   n_p2       out  prize-2 count (saturating)
module lot_ticket_sender #(
  parameter int NDIG  = 5,
  parameter int GAP   = 1,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4*NDIG-1:0] ticket,
  output logic              busy,
  output logic [3:0]        num,
  output logic              insere,
  output logic              fim,
  output logic              fim_jogo,
  input  logic [1:0]        premio_in,
  output logic [1:0]        result,
  output logic              done,
  output logic              bad_digit,
  output logic [CNT_W-1:0]  n_tickets,
  output logic [CNT_W-1:0]  n_p1,
  output logic [CNT_W-1:0]  n_p2
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  // The gap counter counts down to zero, so GAP idle cycles need GAP-1 loaded.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_GAPW = 3'd2,
    S_FIM  = 3'd3,
    S_HOLD = 3'd4,
    S_CLR  = 3'd5,
    S_REJ  = 3'd6
  } state_t;

  state_t            state, state_d;
  logic [4*NDIG-1:0] tkt_q, tkt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              ticket_bad;

  // Next values of the registered outputs
  logic              busy_d, insere_d, fim_d, fim_jogo_d, done_d, bad_d;
  logic [3:0]        num_d;
  logic [1:0]        result_d, premio_s;
  logic [CNT_W-1:0]  n_tickets_d, n_p1_d, n_p2_d;
  logic [4*NDIG-1:0] tkt_sh;

  // Any nibble above 9 makes the whole ticket invalid.
  always_comb begin
    ticket_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (ticket[4*i +: 4] > 4'd9) ticket_bad = 1'b1;
    end
  end

  // State and working registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      tkt_q <= '0;
      idx_q <= '0;
      gap_q <= '0;
    end else begin
      state <= state_d;
      tkt_q <= tkt_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    tkt_d   = tkt_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          tkt_d   = ticket;
          idx_d   = '0;
          state_d = ticket_bad ? S_REJ : S_SEND;
        end
      end
      S_SEND: begin
        if (GAP > 0) begin
          state_d = S_GAPW;
          gap_d   = GAP_LOAD;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_FIM;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SEND;
        end
      end
      S_GAPW: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (idx_q == LAST_IDX) begin
          state_d = S_FIM;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SEND;
        end
      end
      S_FIM:   state_d = S_HOLD;
      S_HOLD:  state_d = S_CLR;
      S_CLR:   state_d = S_IDLE;
      S_REJ:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: outputs are registered, so their next values are
  // decoded from the state being entered.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    insere_d    = (state_d == S_SEND);
    fim_d       = (state_d == S_FIM);
    fim_jogo_d  = (state_d == S_CLR);
    done_d      = (state_d == S_CLR) || (state_d == S_REJ);
    bad_d       = (state_d == S_REJ);
    num_d       = num;
    result_d    = result;
    n_tickets_d = n_tickets;
    n_p1_d      = n_p1;
    n_p2_d      = n_p2;
    premio_s    = (premio_in == 2'b11) ? 2'b00 : premio_in;
    tkt_sh      = tkt_d >> (4 * (NDIG - 1 - int'(idx_d)));

    // num changes only when a new digit is sent and holds through the gap.
    if (state_d == S_SEND) num_d = tkt_sh[3:0];

    if (state_d == S_REJ) result_d = 2'b00;

    // The prize is captured at the end of HOLD. The tallies are updated on
    // the same edge, so they read their new values in the cycle that
    // shows done.
    if (state == S_HOLD && state_d == S_CLR) begin
      result_d = premio_s;
      if (n_tickets != '1) n_tickets_d = n_tickets + CNT_W'(1);
      if (premio_s == 2'b01 && n_p1 != '1) n_p1_d = n_p1 + CNT_W'(1);
      if (premio_s == 2'b10 && n_p2 != '1) n_p2_d = n_p2 + CNT_W'(1);
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      insere    <= 1'b0;
      fim       <= 1'b0;
      fim_jogo  <= 1'b0;
      done      <= 1'b0;
      bad_digit <= 1'b0;
      num       <= 4'd0;
      result    <= 2'b00;
      n_tickets <= '0;
      n_p1      <= '0;
      n_p2      <= '0;
    end else begin
      busy      <= busy_d;
      insere    <= insere_d;
      fim       <= fim_d;
      fim_jogo  <= fim_jogo_d;
      done      <= done_d;
      bad_digit <= bad_d;
      num       <= num_d;
      result    <= result_d;
      n_tickets <= n_tickets_d;
      n_p1      <= n_p1_d;
      n_p2      <= n_p2_d;
    end
  end

endmodule

// File: tb/tb_lot_ticket_sender.sv
// tb_lot_ticket_sender
//   Drives tickets into lot_ticket_sender. A small behavioural checker
//   collects the digits and answers with a prize code. Every output is
//   compared each cycle against a timing/tally model built from the cycle
//   formulas.
module tb_lot_ticket_sender;

  localparam int NDIG    = 5;
  localparam int GAP     = 1;
  localparam int CNT_W   = 5;
  localparam int STEP    = 1 + GAP;
  localparam int FIM_C   = 1 + NDIG * STEP;
  localparam int DONE_C  = FIM_C + 2;
  localparam int SAT     = (1 << CNT_W) - 1;
  localparam logic [19:0] WIN = 20'h47019;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [4*NDIG-1:0] ticket = '0;
  logic              busy, insere, fim, fim_jogo, done, bad_digit;
  logic [3:0]        num;
  logic [1:0]        premio_in = 2'b00;
  logic [1:0]        result;
  logic [CNT_W-1:0]  n_tickets, n_p1, n_p2;

  int n_checks = 0;
  int n_err    = 0;

  // Model state
  int         m_tickets = 0, m_p1 = 0, m_p2 = 0;
  logic [1:0] m_result = 2'b00;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  lot_ticket_sender #(.NDIG(NDIG), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .ticket(ticket), .busy(busy),
    .num(num), .insere(insere), .fim(fim), .fim_jogo(fim_jogo),
    .premio_in(premio_in), .result(result), .done(done),
    .bad_digit(bad_digit), .n_tickets(n_tickets), .n_p1(n_p1), .n_p2(n_p2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Checker rule: exact match wins prize 1; the first two and last digit
  // matching wins prize 2.
  function automatic logic [1:0] prize_of(input logic [19:0] t);
    logic [19:0] w;
    w = WIN;
    if (t == w) return 2'b01;
    if (t[19:12] == w[19:12] && t[3:0] == w[3:0]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit is_valid(input logic [19:0] t);
    for (int i = 0; i < NDIG; i++) if (((t >> (4 * i)) & 20'hF) > 20'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] digit_of(input logic [19:0] t, input int i);
    logic [19:0] s;
    s = t >> (4 * (NDIG - 1 - i));
    return s[3:0];
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_n_tickets"}, 32'(n_tickets), 32'(m_tickets));
    chk({tag, "_n_p1"}, 32'(n_p1), 32'(m_p1));
    chk({tag, "_n_p2"}, 32'(n_p2), 32'(m_p2));
  endtask

  // Called at a negedge with start low. Drives one ticket, then checks every
  // output cycle by cycle until the sender is idle again.
  task automatic run_ticket(input logic [19:0] t, input bit force11, input bit extra);
    bit         valid;
    int         ncyc;
    logic [1:0] p;
    logic [19:0] acc;
    valid = is_valid(t);
    ncyc  = valid ? DONE_C + 2 : 3;
    acc   = '0;
    p     = force11 ? 2'b00 : prize_of(t);
    if (valid) begin
      m_result = p;
      if (m_tickets < SAT) m_tickets++;
      if (p == 2'b01 && m_p1 < SAT) m_p1++;
      if (p == 2'b10 && m_p2 < SAT) m_p2++;
    end else begin
      m_result = 2'b00;
    end
    start  = 1'b1;
    ticket = t;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (valid) begin
        chk("insere", 32'(insere), 32'(c <= 1 + (NDIG - 1) * STEP && (c - 1) % STEP == 0));
        chk("fim", 32'(fim), 32'(c == FIM_C));
        chk("fim_jogo", 32'(fim_jogo), 32'(c == DONE_C));
        chk("done", 32'(done), 32'(c == DONE_C));
        chk("bad_digit", 32'(bad_digit), 32'd0);
        chk("busy", 32'(busy), 32'(c >= 1 && c <= DONE_C));
        if (c <= NDIG * STEP) chk("num", 32'(num), 32'(digit_of(t, (c - 1) / STEP)));
        if (c == DONE_C) begin
          chk("result", 32'(result), 32'(m_result));
          chk_counters("done");
        end
      end else begin
        chk("rej_insere", 32'(insere), 32'd0);
        chk("rej_fim", 32'(fim), 32'd0);
        chk("rej_fim_jogo", 32'(fim_jogo), 32'd0);
        chk("rej_done", 32'(done), 32'(c == 1));
        chk("rej_bad_digit", 32'(bad_digit), 32'(c == 1));
        chk("rej_busy", 32'(busy), 32'(c == 1));
        if (c == 1) begin
          chk("rej_result", 32'(result), 32'd0);
          chk_counters("rej");
        end
      end
      // Behavioural checker reacting to the strobes
      if (insere) acc = {acc[15:0], num};
      if (fim) premio_in = force11 ? 2'b11 : prize_of(acc);
      if (fim_jogo) premio_in = 2'b00;
      // Inputs for the next cycle: stray starts and a scrambled ticket bus
      start  = extra && (c + 1 == 4 || c + 1 == 12);
      ticket = 20'($urandom());
    end
    start = 1'b0;
  endtask

  function automatic logic [19:0] rand_ticket();
    logic [19:0] t;
    int r, pos;
    r = int'($urandom_range(0, 7));
    t = '0;
    for (int i = 0; i < NDIG; i++) t = {t[15:0], 4'($urandom_range(0, 9))};
    if (r == 0) t = WIN;
    else if (r == 1) t = {WIN[19:12], t[11:4], WIN[3:0]};
    else if (r == 2) begin
      pos = int'($urandom_range(0, NDIG - 1));
      t = t & ~(20'hF << (4 * pos));
      t = t | (20'($urandom_range(10, 15)) << (4 * pos));
    end
    return t;
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_counters("rst");
    @(negedge clk);

    // Directed tickets
    run_ticket(20'h47019, 1'b0, 1'b0);
    run_ticket(20'h47559, 1'b0, 1'b0);
    run_ticket(20'h12345, 1'b0, 1'b0);
    run_ticket(20'h4A019, 1'b0, 1'b0);
    run_ticket(20'h47019, 1'b0, 1'b1);

    // Reset in the middle of a ticket
    start  = 1'b1;
    ticket = 20'h47019;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    m_tickets = 0; m_p1 = 0; m_p2 = 0; m_result = 2'b00;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_insere", 32'(insere), 32'd0);
    chk("arst_num", 32'(num), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk_counters("arst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    run_ticket(20'h47019, 1'b0, 1'b0);

    // Random tickets, valid and invalid
    for (int i = 0; i < 20; i++) run_ticket(rand_ticket(), 1'b0, 1'b0);

    // A prize code of 11 counts as no prize
    run_ticket(WIN, 1'b1, 1'b0);

    // Saturation of the tallies
    for (int i = 0; i < 35; i++) run_ticket(WIN, 1'b0, 1'b0);
    chk("sat_n_tickets", 32'(n_tickets), 32'(SAT));
    chk("sat_n_p1", 32'(n_p1), 32'(SAT));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lot_ticket_sender.md
Name: lot_ticket_sender

Overview:
- Transmit side of the lottery digit interface. Takes one 5-digit BCD ticket per start request and presents it to the lottery checker one digit at a time on num/insere.
- Then pulses fim, captures the checker's premio, and pulses fim_jogo to rearm the checker for the next ticket.
- Keeps saturating tallies of tickets sent and prizes won. Sits between the ticket source (keypad/testbench) and the checker.

Parameters:
- NDIG, 5: digits per ticket.
- GAP, 1: idle cycles after each insere pulse (0 allowed).
- CNT_W, 5: width of tally counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request to send ticket; sampled only in IDLE.
- ticket  input  4*NDIG  BCD ticket; digit 0 (first sent) in the most significant nibble.
- busy  output  1  high in every state except IDLE.
- num  output  4  digit presented to checker.
- insere  output  1  one-cycle strobe, num valid.
- fim  output  1  one-cycle end-of-entry strobe.
- fim_jogo  output  1  one-cycle checker rearm strobe.
- premio_in  input  2  checker prize code: 01 = prize 1, 10 = prize 2, 00 = none, 11 = treated as 00.
- result  output  2  captured prize of the last ticket.
- done  output  1  one-cycle completion strobe.
- bad_digit  output  1  one-cycle strobe with done when the ticket was rejected.
- n_tickets  output  CNT_W  valid tickets completed (saturating).
- n_p1  output  CNT_W  prize-1 count (saturating).
- n_p2  output  CNT_W  prize-2 count (saturating).

Behaviour:
- Reset (async) forces:
  - state IDLE; all strobes 0; num 0; result 00; busy 0.
  - all counters 0; internal ticket copy and digit index 0.
  - No fim_jogo is emitted on reset; the checker is expected to share the reset.
- All outputs are registered.
- States: IDLE, SEND, GAPW, FIM, HOLD, CLR, REJ.
- IDLE:
  - On start=1, latch ticket and check every nibble.
  - Any nibble > 9 → REJ. Otherwise → SEND with idx=0.
  - start during any other state is ignored (not queued).
- SEND (1 cycle): insere=1, num=digit[idx].
  - GAP>0 → GAPW for GAP cycles.
  - GAP=0 → next digit, or FIM after the last.
  - num holds its value through GAPW.
- GAPW: after GAP cycles, idx+1 → SEND, or → FIM if idx=NDIG-1.
- FIM (1 cycle): fim=1, insere=0.
- HOLD (1 cycle): fim=0; premio_in is sampled at the end of this cycle into result (11 stored as 00).
- CLR (1 cycle):
  - fim_jogo=1, done=1.
  - n_tickets += 1; n_p1 += 1 if result=01; n_p2 += 1 if result=10.
  - All counters stick at all-ones.
  - → IDLE.
- REJ (1 cycle):
  - done=1, bad_digit=1, result=00.
  - No insere/fim/fim_jogo issued; no counter changes.
  - → IDLE.
- Timing, with the cycle where start is sampled as cycle 0:
  - insere for digit i in cycle 1+i*(1+GAP).
  - fim in cycle 1+NDIG*(1+GAP).
  - done/fim_jogo 2 cycles later.
  - Defaults (NDIG=5, GAP=1): insere at 1,3,5,7,9; fim 11; done 13.
- Strobes never overlap: insere, fim and fim_jogo are mutually exclusive each cycle.
- Ticket input changes after start has been sampled have no effect.
- Reset mid-ticket: immediate abort, no done. A new start is accepted on the first clock after reset is released.

Test Plan:
- Reset, then start with ticket=0x47019, GAP=1, real checker attached → num 4,7,0,1,9 with insere at cycles 1,3,5,7,9; fim at 11; done+fim_jogo at 13; result=01; n_tickets=1, n_p1=1.
- ticket=0x47559 → result=10, n_p2 increments; ticket=0x12345 → result=00, only n_tickets increments.
- ticket=0x4A019 → done+bad_digit at cycle 1; no insere/fim/fim_jogo; counters unchanged; result=00.
- start pulsed again at cycles 4 and 12 of a ticket in progress → ignored; exactly one done; busy=1 cycles 1-13.
- Assert reset at cycle 6 of a ticket → all outputs 0 asynchronously, no done; a new start after release completes normally.
- Drive 35 winning tickets with CNT_W=5 → n_tickets and n_p1 stick at 31; premio_in forced to 11 → result=00, no prize count.
